// File: rtl/apmu_ibex_pkg.sv
// Shared types and constants for the APMU-side PMC responder.
//   csr_op_e         : CSR-style operation applied to an event counter
//   pmc_rsp_state_e  : responder FSM states
//   CSR_MHPMCOUNTER3 : CSR address of the first event counter
//   PMC_CNT_W        : event counter width
//   csr_apply()      : result of applying a csr_op_e to a counter value
package apmu_ibex_pkg;

   localparam int unsigned PMC_CNT_W = 32;
   localparam logic [11:0] CSR_MHPMCOUNTER3 = 12'hB03;

   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'd0,
      CSR_OP_WRITE = 2'd1,
      CSR_OP_SET   = 2'd2,
      CSR_OP_CLEAR = 2'd3
   } csr_op_e;

   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_WFP  = 2'd1,
      RSP_EXEC = 2'd2,
      RSP_RESP = 2'd3
   } pmc_rsp_state_e;

   function automatic logic [PMC_CNT_W-1:0] csr_apply(
      input csr_op_e              op,
      input logic [PMC_CNT_W-1:0] cur,
      input logic [PMC_CNT_W-1:0] operand
   );
      logic [PMC_CNT_W-1:0] res;
      case (op)
         CSR_OP_WRITE: res = operand;
         CSR_OP_SET:   res = cur | operand;
         CSR_OP_CLEAR: res = cur & ~operand;
         default:      res = cur;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/apmu_pmc_counter.sv
// One 32-bit event counter.
//   clk_i, rst_ni : clock, async active-low reset
//   inc           : count one event this cycle
//   wr_en         : load wr_data this cycle (takes priority over inc)
//   wr_data       : value to load
//   value         : current count
//   wrap          : pulse, the increment this cycle wraps the counter to 0
//   ovf           : sticky overflow flag (only with PMC_OVF_IRQ_EN, else 0)
// Build option: PMC_OVF_IRQ_EN adds the sticky overflow flag.
module apmu_pmc_counter
   import apmu_ibex_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 inc,
   input  logic                 wr_en,
   input  logic [PMC_CNT_W-1:0] wr_data,
   output logic [PMC_CNT_W-1:0] value,
   output logic                 wrap,
   output logic                 ovf
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value <= '0;
      end else if (wr_en) begin
         value <= wr_data;
      end else if (inc) begin
         value <= value + 1'b1;
      end
   end

   // A write in the same cycle swallows the event, so it cannot wrap.
   assign wrap = inc & ~wr_en & (&value);

`ifdef PMC_OVF_IRQ_EN
   logic ovf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_q <= 1'b0;
      end else if (wr_en) begin
         ovf_q <= 1'b0;
      end else if (wrap) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: rtl/apmu_pmc_responder.sv
// APMU-side responder for the core's PMC access protocol. Owns a bank of
// event counters, grants a core request once the APMU lock is released,
// executes one CSR-style op on the addressed counter and returns the
// pre-op value.
//   clk_i, rst_ni : clock, async active-low reset
//   pmc_req_i     : core request (op/addr/wdata stable until grant)
//   pmc_op_i      : csr_op_e
//   pmc_addr_i    : counter CSR address
//   pmc_wdata_i   : write/set/clear operand
//   pmc_gnt_o     : 1-cycle grant, request captured this cycle
//   pmc_rvalid_o  : 1-cycle response valid
//   pmc_rdata_o   : pre-op counter value (0 on error), held between responses
//   pmc_err_o     : address outside counter range, held between responses
//   apmu_lock_i   : APMU holds the counters, blocks grant
//   event_i       : per-counter increment strobes
//   irq_ovf_o     : counter overflow interrupt (0 unless PMC_OVF_IRQ_EN)
// Build option: PMC_OVF_IRQ_EN enables the registered overflow interrupt.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RSP_IDLE | no request pending
// RSP_WFP  | request seen, waiting for lock release to grant
// RSP_EXEC | decode captured address, apply op, capture pre-op value
// RSP_RESP | response valid for one cycle
module apmu_pmc_responder
   import apmu_ibex_pkg::*;
#(
   parameter int unsigned NumCounters = 8,
   parameter logic [11:0] BaseAddr    = CSR_MHPMCOUNTER3
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   pmc_req_i,
   input  logic [1:0]             pmc_op_i,
   input  logic [11:0]            pmc_addr_i,
   input  logic [PMC_CNT_W-1:0]   pmc_wdata_i,
   output logic                   pmc_gnt_o,
   output logic                   pmc_rvalid_o,
   output logic [PMC_CNT_W-1:0]   pmc_rdata_o,
   output logic                   pmc_err_o,
   input  logic                   apmu_lock_i,
   input  logic [NumCounters-1:0] event_i,
   output logic                   irq_ovf_o
);

   pmc_rsp_state_e       state_q, state_d;
   csr_op_e              op_q;
   logic [11:0]          addr_q;
   logic [PMC_CNT_W-1:0] wdata_q;
   logic [PMC_CNT_W-1:0] rdata_q;
   logic                 err_q;

   logic [11:0]          idx;
   logic                 in_range;
   logic                 exec;
   logic [PMC_CNT_W-1:0] cur_val;
   logic [PMC_CNT_W-1:0] wr_data;
   logic [NumCounters-1:0] wr_en;
   logic [NumCounters-1:0] wrap_vec;
   logic [NumCounters-1:0] ovf_vec;
   logic [PMC_CNT_W-1:0] cnt_val [NumCounters];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RSP_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pmc_gnt_o = 1'b0;
      case (state_q)
         RSP_IDLE: if (pmc_req_i) state_d = RSP_WFP;
         RSP_WFP: begin
            if (!pmc_req_i) begin
               state_d = RSP_IDLE;
            end else if (!apmu_lock_i) begin
               pmc_gnt_o = 1'b1;
               state_d   = RSP_EXEC;
            end
         end
         RSP_EXEC: state_d = RSP_RESP;
         RSP_RESP: state_d = RSP_IDLE;
         default:  state_d = RSP_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q    <= CSR_OP_READ;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (pmc_gnt_o) begin
         op_q    <= csr_op_e'(pmc_op_i);
         addr_q  <= pmc_addr_i;
         wdata_q <= pmc_wdata_i;
      end
   end

   // Explicit lower-bound compare so addresses below BaseAddr never alias
   // into range through the subtraction wrapping.
   assign idx      = addr_q - BaseAddr;
   assign in_range = (addr_q >= BaseAddr) && (idx < 12'(NumCounters));
   assign exec     = (state_q == RSP_EXEC);

   always_comb begin
      cur_val = '0;
      wr_en   = '0;
      for (int k = 0; k < int'(NumCounters); k++) begin
         if (idx == 12'(k)) begin
            cur_val  = cnt_val[k];
            wr_en[k] = exec && in_range && (op_q != CSR_OP_READ);
         end
      end
   end

   // Shared by all counters; only the enabled one loads it.
   assign wr_data = csr_apply(op_q, cur_val, wdata_q);

   for (genvar g = 0; g < int'(NumCounters); g++) begin : g_cnt
      apmu_pmc_counter u_cnt (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .inc     (event_i[g]),
         .wr_en   (wr_en[g]),
         .wr_data (wr_data),
         .value   (cnt_val[g]),
         .wrap    (wrap_vec[g]),
         .ovf     (ovf_vec[g])
      );
   end

   logic unused_wrap;
   assign unused_wrap = ^wrap_vec;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (exec) begin
         rdata_q <= in_range ? cur_val : '0;
         err_q   <= ~in_range;
      end
   end

   assign pmc_rvalid_o = (state_q == RSP_RESP);
   assign pmc_rdata_o  = rdata_q;
   assign pmc_err_o    = err_q;

`ifdef PMC_OVF_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |ovf_vec;
      end
   end

   assign irq_ovf_o = irq_q;
`else
   logic unused_ovf;
   assign unused_ovf = ^ovf_vec;
   assign irq_ovf_o  = 1'b0;
`endif

endmodule

// File: tb/tb_apmu_pmc_responder.sv
module tb_apmu_pmc_responder;
   import apmu_ibex_pkg::*;

   localparam int          NC   = 8;
   localparam logic [11:0] BASE = 12'hB03;
`ifdef PMC_OVF_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req;
   logic [1:0]  op_drv;
   logic [11:0] addr_drv;
   logic [31:0] wd_drv;
   logic        lock;
   logic [7:0]  ev;
   logic        pmc_gnt_o, pmc_rvalid_o, pmc_err_o, irq_ovf_o;
   logic [31:0] pmc_rdata_o;

   apmu_pmc_responder #(.NumCounters(NC), .BaseAddr(BASE)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .pmc_req_i    (req),
      .pmc_op_i     (op_drv),
      .pmc_addr_i   (addr_drv),
      .pmc_wdata_i  (wd_drv),
      .pmc_gnt_o    (pmc_gnt_o),
      .pmc_rvalid_o (pmc_rvalid_o),
      .pmc_rdata_o  (pmc_rdata_o),
      .pmc_err_o    (pmc_err_o),
      .apmu_lock_i  (lock),
      .event_i      (ev),
      .irq_ovf_o    (irq_ovf_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: counter contents, sticky overflow flags, interrupt.
   logic [31:0] cnt_m [NC];
   logic [NC-1:0] ovf_m;
   logic        irq_m;
   bit          exec_now, exec_next;
   logic [1:0]  l_op;
   logic [11:0] l_addr;
   logic [31:0] l_wd;
   logic [31:0] exp_rdata;
   logic        exp_err;

   // Last sampled DUT outputs.
   logic        s_gnt, s_rvalid, s_err, s_irq;
   logic [31:0] s_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reset_model();
      for (int k = 0; k < NC; k++) cnt_m[k] = '0;
      ovf_m     = '0;
      irq_m     = 1'b0;
      exec_now  = 0;
      exec_next = 0;
   endtask

   function automatic logic [31:0] op_result(input logic [1:0] op, input logic [31:0] c,
                                             input logic [31:0] w);
      case (op)
         2'd1:    return w;
         2'd2:    return c | w;
         2'd3:    return c & ~w;
         default: return c;
      endcase
   endfunction

   // One clock cycle: sample at negedge, advance model at posedge, then
   // return 1 time unit after the edge so the caller can drive new inputs.
   task automatic tick();
      logic [31:0] pre [NC];
      int          idx;
      bit          inr;
      @(negedge clk_i);
      s_gnt    = pmc_gnt_o;
      s_rvalid = pmc_rvalid_o;
      s_rdata  = pmc_rdata_o;
      s_err    = pmc_err_o;
      s_irq    = irq_ovf_o;
      chk("irq", 32'(s_irq), 32'(IRQ_EN ? irq_m : 1'b0));
      exec_now  = exec_next;
      exec_next = s_gnt;
      if (s_gnt) begin
         l_op   = op_drv;
         l_addr = addr_drv;
         l_wd   = wd_drv;
      end
      @(posedge clk_i);
      irq_m = |ovf_m;
      pre   = cnt_m;
      idx   = int'(l_addr) - int'(BASE);
      inr   = (idx >= 0) && (idx < NC);
      if (exec_now) begin
         exp_rdata = inr ? pre[idx] : 32'h0;
         exp_err   = ~inr;
      end
      for (int k = 0; k < NC; k++) begin
         if (exec_now && inr && idx == k && l_op != 2'd0) begin
            cnt_m[k] = op_result(l_op, pre[k], l_wd);
            ovf_m[k] = 1'b0;
         end else if (ev[k]) begin
            cnt_m[k] = pre[k] + 32'd1;
            if (pre[k] == 32'hFFFF_FFFF) ovf_m[k] = 1'b1;
         end
      end
      #1;
   endtask

   // Full transaction. Lock is held for lock_cycles cycles counted from the
   // cycle req rises, so the grant must land at cycle max(1, lock_cycles).
   task automatic do_op(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        input int lock_cycles, input bit rnd_ev, input logic [7:0] ev_exec,
                        output logic [31:0] rd, output logic er);
      int gnt_t;
      int exp_t;
      op_drv   = op;
      addr_drv = addr;
      wd_drv   = wd;
      req      = 1'b1;
      gnt_t    = -1;
      rd       = '0;
      er       = 1'b0;
      for (int t = 0; t < 40 && gnt_t < 0; t++) begin
         lock = (t < lock_cycles);
         ev   = rnd_ev ? 8'($urandom) : 8'h00;
         tick();
         if (s_gnt) gnt_t = t;
      end
      exp_t = (lock_cycles > 1) ? lock_cycles : 1;
      chk("gnt_cycle", 32'(gnt_t), 32'(exp_t));
      req = 1'b0;
      if (gnt_t < 0) begin
         lock = 1'b0;
         ev   = '0;
         return;
      end
      lock = rnd_ev ? 1'($urandom) : 1'b0;
      ev   = rnd_ev ? 8'($urandom) : ev_exec;
      tick();
      chk("rvalid_in_exec", 32'(s_rvalid), 32'd0);
      ev = rnd_ev ? 8'($urandom) : 8'h00;
      tick();
      chk("rvalid_resp", 32'(s_rvalid), 32'd1);
      chk("rdata_model", s_rdata, exp_rdata);
      chk("err_model", 32'(s_err), 32'(exp_err));
      rd   = s_rdata;
      er   = s_err;
      lock = 1'b0;
      ev   = '0;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t        vecs [10];
   logic [31:0] rd;
   logic        er;
   int          gnt_seen, rv_seen;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni   = 1'b0;
      req      = 1'b0;
      op_drv   = '0;
      addr_drv = '0;
      wd_drv   = '0;
      lock     = 1'b0;
      ev       = '0;
      s_gnt    = 0; s_rvalid = 0; s_err = 0; s_irq = 0; s_rdata = '0;
      l_op     = '0; l_addr = '0; l_wd = '0; exp_rdata = '0; exp_err = 0;
      reset_model();
      #12;
      chk("rst_gnt", 32'(pmc_gnt_o), 32'd0);
      chk("rst_rvalid", 32'(pmc_rvalid_o), 32'd0);
      chk("rst_rdata", pmc_rdata_o, 32'd0);
      chk("rst_err", 32'(pmc_err_o), 32'd0);
      chk("rst_irq", 32'(irq_ovf_o), 32'd0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Directed ops, no events, no lock. Counter k lives at B03+k.
      vecs[0] = '{2'd1, 12'hB03, 32'h0000_0010, 32'h0000_0000, 1'b0};
      vecs[1] = '{2'd0, 12'hB03, 32'h0000_0000, 32'h0000_0010, 1'b0};
      vecs[2] = '{2'd1, 12'hB0A, 32'h1234_5678, 32'h0000_0000, 1'b0};
      vecs[3] = '{2'd2, 12'hB0A, 32'h0000_000F, 32'h1234_5678, 1'b0};
      vecs[4] = '{2'd3, 12'hB0A, 32'h0000_0070, 32'h1234_567F, 1'b0};
      vecs[5] = '{2'd0, 12'hB0A, 32'h0000_0000, 32'h1234_560F, 1'b0};
      vecs[6] = '{2'd0, 12'hB0B, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[7] = '{2'd1, 12'hB02, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
      vecs[8] = '{2'd0, 12'hB03, 32'h0000_0000, 32'h0000_0010, 1'b0};
      vecs[9] = '{2'd1, 12'hB03, 32'h0000_000F, 32'h0000_0010, 1'b0};
      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].op, vecs[i].addr, vecs[i].wd, 0, 1'b0, 8'h00, rd, er);
         chk("vec_rdata", rd, vecs[i].exp_rd);
         chk("vec_err", 32'(er), 32'(vecs[i].exp_err));
      end

      // SET with a same-cycle event on counter 0: op wins, event lost.
      do_op(2'd2, 12'hB03, 32'h0000_00F0, 0, 1'b0, 8'h01, rd, er);
      chk("set_ev_rdata", rd, 32'h0000_000F);
      do_op(2'd0, 12'hB03, 32'h0, 0, 1'b0, 8'h00, rd, er);
      chk("set_ev_cnt", rd, 32'h0000_00FF);
      do_op(2'd3, 12'hB03, 32'h0000_000F, 0, 1'b0, 8'h00, rd, er);
      chk("clear_rdata", rd, 32'h0000_00FF);
      do_op(2'd0, 12'hB03, 32'h0, 0, 1'b0, 8'h00, rd, er);
      chk("clear_cnt", rd, 32'h0000_00F0);
      // READ with a same-cycle event: event counts, rdata pre-increment.
      do_op(2'd0, 12'hB03, 32'h0, 0, 1'b0, 8'h01, rd, er);
      chk("read_ev_rdata", rd, 32'h0000_00F0);
      tick();
      chk("hold_rdata", s_rdata, 32'h0000_00F0);
      chk("hold_rvalid", 32'(s_rvalid), 32'd0);
      do_op(2'd0, 12'hB03, 32'h0, 0, 1'b0, 8'h00, rd, er);
      chk("read_ev_cnt", rd, 32'h0000_00F1);

      // Lock held for 5 WFP cycles, then released.
      do_op(2'd0, 12'hB04, 32'h0, 6, 1'b0, 8'h00, rd, er);
      chk("lock_rdata", rd, 32'h0);

      // Abort in WFP: no grant, no response.
      op_drv = 2'd1; addr_drv = 12'hB04; wd_drv = 32'hDEAD_BEEF;
      req = 1'b1; lock = 1'b1;
      gnt_seen = 0; rv_seen = 0;
      for (int t = 0; t < 7; t++) begin
         if (t == 3) req = 1'b0;
         tick();
         gnt_seen += int'(s_gnt);
         rv_seen  += int'(s_rvalid);
      end
      lock = 1'b0;
      chk("abort_gnt", 32'(gnt_seen), 32'd0);
      chk("abort_rvalid", 32'(rv_seen), 32'd0);
      do_op(2'd0, 12'hB04, 32'h0, 0, 1'b0, 8'h00, rd, er);
      chk("abort_nowrite", rd, 32'h0);

      // Counter 2 wraps through 0 after three events.
      do_op(2'd1, 12'hB05, 32'hFFFF_FFFE, 0, 1'b0, 8'h00, rd, er);
      ev = 8'h04;
      for (int t = 0; t < 3; t++) tick();
      ev = 8'h00;
      tick();
      do_op(2'd0, 12'hB05, 32'h0, 0, 1'b0, 8'h00, rd, er);
      chk("wrap_cnt", rd, 32'h0000_0001);
      chk("wrap_irq", 32'(s_irq), 32'(IRQ_EN));
      do_op(2'd3, 12'hB05, 32'h0, 0, 1'b0, 8'h00, rd, er);
      tick();
      chk("irq_cleared", 32'(s_irq), 32'd0);

      // Reset while in EXEC: outputs drop at once, op dropped.
      do_op(2'd0, 12'hB0A, 32'h0, 0, 1'b0, 8'h00, rd, er);
      chk("pre_rst_rdata", rd, 32'h1234_560F);
      op_drv = 2'd1; addr_drv = 12'hB03; wd_drv = 32'h5555_5555;
      req = 1'b1;
      tick();
      tick();
      chk("rst_exec_gnt", 32'(s_gnt), 32'd1);
      req = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_rvalid", 32'(pmc_rvalid_o), 32'd0);
      chk("rst_mid_rdata", pmc_rdata_o, 32'd0);
      chk("rst_mid_err", 32'(pmc_err_o), 32'd0);
      chk("rst_mid_irq", 32'(irq_ovf_o), 32'd0);
      reset_model();
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      rv_seen = 0;
      for (int t = 0; t < 4; t++) begin
         tick();
         rv_seen += int'(s_rvalid);
      end
      chk("rst_no_rvalid", 32'(rv_seen), 32'd0);
      do_op(2'd0, 12'hB03, 32'h0, 0, 1'b0, 8'h00, rd, er);
      chk("rst_cnt0", rd, 32'h0);
      do_op(2'd0, 12'hB0A, 32'h0, 0, 1'b0, 8'h00, rd, er);
      chk("rst_cnt7", rd, 32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 200; i++) begin
         logic [1:0]  r_op;
         logic [11:0] r_addr;
         logic [31:0] r_wd;
         r_op   = 2'($urandom_range(0, 3));
         r_addr = 12'hB01 + 12'($urandom_range(0, 12));
         r_wd   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
         do_op(r_op, r_addr, r_wd, int'($urandom_range(0, 3)), 1'b1, 8'h00, rd, er);
         if ($urandom_range(0, 3) == 0) begin
            ev = 8'($urandom);
            tick();
            ev = '0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
